// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Provides read-mode encodings and the pointer width helper.
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
// Ports: clk, we, waddr, wdata (write side); raddr, rdata (read side).
module fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered or FWFT read data,
// fill count, almost-full/empty thresholds and sticky error flags.
// Ports: clk, rst (sync, active-high); wen/data_in write side;
// ren/data_out read side; full, empty, almost_full, almost_empty,
// count status; overflow/underflow sticky errors cleared by clr_err.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FWFT_OFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic                     ren,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE  = PW'(1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $fatal(1, "fifo_sync_param: AF_LEVEL out of range");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $fatal(1, "fifo_sync_param: AE_LEVEL out of range");
    end
    if ((FWFT != FWFT_OFF) && (FWFT != FWFT_ON)) begin : g_bad_mode
        $fatal(1, "fifo_sync_param: FWFT must be 0 or 1");
    end

    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rdata;

    // Same address with differing wrap bits means the writer lapped the reader.
    assign empty        = (wptr == rptr);
    assign full         = (wptr[AW] != rptr[AW]) &&
                          (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    assign wr_acc = wen && !full;
    assign rd_acc = ren && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + ONE;
            end
            // A new error event takes priority over a clear in the same cycle.
            if (wen && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (wr_acc && !rst),
        .waddr  (wptr[AW-1:0]),
        .wdata  (data_in),
        .raddr  (rptr[AW-1:0]),
        .rdata  (rdata)
    );

    if (FWFT == FWFT_OFF) begin : g_reg_out
        logic [DATA_W-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rdata;
            end
        end

        assign data_out = dout_q;
    end else begin : g_fwft_out
        // Head word is presented directly; meaningless while empty.
        assign data_out = rdata;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: registered-output and FWFT instances.
// Stimulus pushes expected read data; a monitor pops and compares.
module tb_fifo_sync_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        full, empty, almost_full, almost_empty;
    logic [3:0]  count;
    logic        overflow, underflow;

    logic        f_rst = 1'b0;
    logic        f_wen = 1'b0;
    logic        f_ren = 1'b0;
    logic        f_clr = 1'b0;
    logic [31:0] f_din = '0;
    logic [31:0] f_dout;
    logic        f_full, f_empty, f_af, f_ae;
    logic [3:0]  f_count;
    logic        f_ovf, f_unf;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    bit          movf = 1'b0;
    bit          munf = 1'b0;
    event        rd_ev;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
    ) u_dut (
        .clk(clk), .rst(rst), .wen(wen), .ren(ren),
        .data_in(data_in), .data_out(data_out),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err)
    );

    fifo_sync_param #(
        .DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(f_rst), .wen(f_wen), .ren(f_ren),
        .data_in(f_din), .data_out(f_dout),
        .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf),
        .clr_err(f_clr)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each accepted read presents its word one cycle later.
    always begin
        @(rd_ev);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rdata: got %h expected <none>", data_out);
        end else begin
            chk("rdata", data_out, exp_q.pop_front());
        end
    end

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == 8));
        chk("almost_full", 32'(almost_full), 32'(n >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("underflow", 32'(underflow), 32'(munf));
    endtask

    task automatic step(input logic w, input logic r, input logic c,
                        input logic [31:0] d);
        bit f, e;
        wen = w; ren = r; clr_err = c; data_in = d;
        @(posedge clk);
        f = (mq.size() == 8);
        e = (mq.size() == 0);
        if (r && !e) begin
            exp_q.push_back(mq.pop_front());
            -> rd_ev;
        end
        if (w && !f) mq.push_back(d);
        if (w && f) movf = 1'b1;
        else if (c) movf = 1'b0;
        if (r && e) munf = 1'b1;
        else if (c) munf = 1'b0;
        @(negedge clk);
        wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
        check_all();
    endtask

    task automatic do_reset(input logic w, input logic r);
        rst = 1'b1; wen = w; ren = r; data_in = 32'h999;
        @(posedge clk);
        mq.delete();
        movf = 1'b0;
        munf = 1'b0;
        @(negedge clk);
        rst = 1'b0; wen = 1'b0; ren = 1'b0;
        check_all();
        chk("reset_dout", data_out, 32'h0);
    endtask

    task automatic fstep(input logic w, input logic r, input logic [31:0] d);
        f_wen = w; f_ren = r; f_din = d;
        @(posedge clk);
        @(negedge clk);
        f_wen = 1'b0; f_ren = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset(1'b1, 1'b1);

        // Fill with 0x10..0x17, then drain.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 32'h10 + 32'(i));
        chk("s1_full", 32'(full), 32'h1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        chk("s1_last", data_out, 32'h17);
        chk("s1_empty", 32'(empty), 32'h1);

        // Overflow: dropped write, sticky flag, clear.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 32'h20 + 32'(i));
        step(1, 0, 0, 32'hDEAD);
        chk("s2_ovf", 32'(overflow), 32'h1);
        chk("s2_count", 32'(count), 32'h8);
        step(0, 0, 1, 0);
        chk("s2_clr", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);

        // Underflow: hold data, set beats clear.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("s3_unf", 32'(underflow), 32'h1);
        chk("s3_hold", data_out, 32'h27);
        step(0, 1, 1, 0);
        chk("s3_setwins", 32'(underflow), 32'h1);
        step(0, 0, 1, 0);
        chk("s3_clr", 32'(underflow), 32'h0);

        // Steady state at count 4 with pointer wraparound.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h100 + 32'(i));
        for (int i = 0; i < 20; i++) step(1, 1, 0, 32'h104 + 32'(i));
        chk("s4_count", 32'(count), 32'h4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        chk("s4_last", data_out, 32'h117);

        // Reset mid-operation discards contents.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h200 + 32'(i));
        step(0, 1, 0, 0);
        do_reset(1'b1, 1'b1);
        chk("s6_empty", 32'(empty), 32'h1);
        step(1, 0, 0, 32'h300);
        step(0, 1, 0, 0);
        chk("s6_new", data_out, 32'h300);

        // FWFT instance.
        f_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f_rst = 1'b0;
        chk("f_reset_empty", 32'(f_empty), 32'h1);
        fstep(1, 0, 32'hA5A5A5A5);
        chk("f_empty", 32'(f_empty), 32'h0);
        chk("f_head", f_dout, 32'hA5A5A5A5);
        fstep(1, 0, 32'h5A5A5A5A);
        chk("f_head_kept", f_dout, 32'hA5A5A5A5);
        chk("f_count", 32'(f_count), 32'h2);
        fstep(0, 1, 0);
        chk("f_pop", f_dout, 32'h5A5A5A5A);
        fstep(0, 1, 0);
        chk("f_drained", 32'(f_empty), 32'h1);
        chk("f_unf", 32'(f_unf), 32'h0);

        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
